// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// hazard_ctrl_unit: EX/MEM/WB destination-tag shadow with forwarding, load-use stall, flush, freeze.
// Optional: HAZARD_WB_BYPASS_EN makes a WB-stage match select 11 (read-before-write regfile). Rev 1.0
module hazard_ctrl_unit #(
  parameter int REG_AW  = 2,
  parameter int NUM_SRC = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_use,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_wr,
  input  logic                      id_rm,
  input  logic                      br_taken,
  input  logic                      mem_wait,
  output logic                      stall,
  output logic                      bubble,
  output logic                      flush,
  output logic                      freeze,
  output logic [2*NUM_SRC-1:0]      fwd
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              rm;
  } tag_t;

`ifdef HAZARD_WB_BYPASS_EN
  localparam logic [1:0] WB_SEL = 2'b11;
`else
  localparam logic [1:0] WB_SEL = 2'b00;
`endif

  tag_t ex_q, mem_q, wb_q;
  tag_t ex_d, mem_d, wb_d;

  logic [NUM_SRC-1:0] lu_vec;
  logic               load_use;
  logic               stall_c, bubble_c, flush_c, freeze_c;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_AW-1:0] src;
    logic              rd_en;
    logic              m_ex, m_mem, m_wb;
    logic [1:0]        sel;

    assign src   = id_src[k*REG_AW +: REG_AW];
    assign rd_en = id_valid & id_src_use[k];
    assign m_ex  = rd_en & ex_q.valid  & ex_q.wr  & (ex_q.rd  == src);
    assign m_mem = rd_en & mem_q.valid & mem_q.wr & (mem_q.rd == src);
    assign m_wb  = rd_en & wb_q.valid  & wb_q.wr  & (wb_q.rd  == src);

    // A load in EX cannot forward yet; fall through to older stages while the stall is issued.
    always_comb begin
      sel = 2'b00;
      if (m_ex & ~ex_q.rm) sel = 2'b01;
      else if (m_mem)      sel = 2'b10;
      else if (m_wb)       sel = WB_SEL;
    end

    assign lu_vec[k]       = m_ex & ex_q.rm;
    assign fwd[2*k +: 2]   = reset_n ? sel : 2'b00;
  end

  assign load_use = |lu_vec;

  always_comb begin
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    freeze_c = 1'b0;
    ex_d     = ex_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    if (mem_wait) begin
      freeze_c = 1'b1;
      stall_c  = 1'b1;
    end else if (br_taken) begin
      flush_c = 1'b1;
      wb_d    = mem_q;
      mem_d   = '0;
      ex_d    = '0;
    end else if (load_use) begin
      stall_c  = 1'b1;
      bubble_c = 1'b1;
      wb_d     = mem_q;
      mem_d    = ex_q;
      ex_d     = '0;
    end else begin
      wb_d        = mem_q;
      mem_d       = ex_q;
      ex_d.valid  = id_valid;
      ex_d.rd     = id_rd;
      ex_d.wr     = id_wr & id_valid;
      ex_d.rm     = id_rm & id_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign stall  = reset_n & stall_c;
  assign bubble = reset_n & bubble_c;
  assign flush  = reset_n & flush_c;
  assign freeze = reset_n & freeze_c;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// tb_hazard_ctrl_unit: directed scenarios plus randomized traffic against an in-flight instruction model.
module tb_hazard_ctrl_unit;
  localparam int REG_AW  = 2;
  localparam int NUM_SRC = 2;

`ifdef HAZARD_WB_BYPASS_EN
  localparam logic [1:0] WB_CODE = 2'b11;
`else
  localparam logic [1:0] WB_CODE = 2'b00;
`endif

  logic                      clock = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      id_valid = 1'b0;
  logic [NUM_SRC*REG_AW-1:0] id_src = '0;
  logic [NUM_SRC-1:0]        id_src_use = '0;
  logic [REG_AW-1:0]         id_rd = '0;
  logic                      id_wr = 1'b0, id_rm = 1'b0, br_taken = 1'b0, mem_wait = 1'b0;
  logic                      stall, bubble, flush, freeze;
  logic [2*NUM_SRC-1:0]      fwd;

  int total = 0;
  int bad   = 0;

  // In-flight instructions indexed by age: 1 = one ahead of ID (EX), 2 = MEM, 3 = WB.
  logic              m_v  [1:3];
  logic [REG_AW-1:0] m_rd [1:3];
  logic              m_wr [1:3];
  logic              m_rm [1:3];

  hazard_ctrl_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_use(id_src_use), .id_rd(id_rd), .id_wr(id_wr), .id_rm(id_rm),
    .br_taken(br_taken), .mem_wait(mem_wait), .stall(stall), .bubble(bubble),
    .flush(flush), .freeze(freeze), .fwd(fwd)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic produces(input int age, input int k);
    logic [REG_AW-1:0] s;
    s = id_src[k*REG_AW +: REG_AW];
    return id_valid && id_src_use[k] && m_v[age] && m_wr[age] && (m_rd[age] == s);
  endfunction

  function automatic logic [1:0] exp_fwd(input int k);
    if (!reset_n)                        return 2'b00;
    if (produces(1, k) && !m_rm[1])      return 2'b01;
    if (produces(2, k))                  return 2'b10;
    if (produces(3, k))                  return WB_CODE;
    return 2'b00;
  endfunction

  function automatic logic load_dep();
    for (int k = 0; k < NUM_SRC; k++)
      if (produces(1, k) && m_rm[1]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] fwd_of(input int k);
    return fwd[2*k +: 2];
  endfunction

  task automatic put(input logic v, input int s0, input int s1, input int use_m,
                     input int rd, input logic wr, input logic rm, input logic br, input logic mw);
    id_valid   = v;
    id_src     = {s1[REG_AW-1:0], s0[REG_AW-1:0]};
    id_src_use = use_m[NUM_SRC-1:0];
    id_rd      = rd[REG_AW-1:0];
    id_wr      = wr;
    id_rm      = rm;
    br_taken   = br;
    mem_wait   = mw;
  endtask

  task automatic idle();
    put(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Check every output against the model, clock once, then age the model.
  task automatic step();
    logic es, eb, ef, ez, ld;
    #2;
    ld = load_dep();
    es = 1'b0; eb = 1'b0; ef = 1'b0; ez = 1'b0;
    if (reset_n) begin
      if (mem_wait)      begin ez = 1'b1; es = 1'b1; end
      else if (br_taken) ef = 1'b1;
      else if (ld)       begin es = 1'b1; eb = 1'b1; end
    end
    check("stall", int'(stall), int'(es));
    check("bubble", int'(bubble), int'(eb));
    check("flush", int'(flush), int'(ef));
    check("freeze", int'(freeze), int'(ez));
    for (int k = 0; k < NUM_SRC; k++) check($sformatf("fwd%0d", k), int'(fwd_of(k)), int'(exp_fwd(k)));
    @(posedge clock);
    if (!reset_n) begin
      for (int a = 1; a <= 3; a++) begin m_v[a] = 0; m_rd[a] = '0; m_wr[a] = 0; m_rm[a] = 0; end
    end else if (!mem_wait) begin
      m_v[3] = m_v[2]; m_rd[3] = m_rd[2]; m_wr[3] = m_wr[2]; m_rm[3] = m_rm[2];
      if (br_taken) begin
        m_v[2] = 0; m_wr[2] = 0; m_rm[2] = 0;
        m_v[1] = 0; m_wr[1] = 0; m_rm[1] = 0;
      end else begin
        m_v[2] = m_v[1]; m_rd[2] = m_rd[1]; m_wr[2] = m_wr[1]; m_rm[2] = m_rm[1];
        if (ld) begin
          m_v[1] = 0; m_wr[1] = 0; m_rm[1] = 0;
        end else begin
          m_v[1] = id_valid; m_rd[1] = id_rd; m_wr[1] = id_wr & id_valid; m_rm[1] = id_rm & id_valid;
        end
      end
    end
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  initial begin
    for (int a = 1; a <= 3; a++) begin m_v[a] = 0; m_rd[a] = '0; m_wr[a] = 0; m_rm[a] = 0; end
    #1;

    // Reset with busy inputs: everything quiet.
    reset_n = 1'b0;
    put(1'b1, 1, 1, 3, 1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) begin
      #1; check("rst_stall", int'(stall), 0); check("rst_freeze", int'(freeze), 0);
      check("rst_fwd", int'(fwd), 0);
      step();
    end
    reset_n = 1'b1;
    put(1'b1, 2, 0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; check("post_rst_fwd", int'(fwd), 0);
    step();
    drain();

    // ALU RAW at distance 1, 2, 3.
    put(1'b1, 0, 0, 0, 2, 1'b1, 1'b0, 1'b0, 1'b0); step();
    put(1'b1, 2, 0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; check("raw_d1", int'(fwd[1:0]), 1); step();
    drain();
    put(1'b1, 0, 0, 0, 2, 1'b1, 1'b0, 1'b0, 1'b0); step();
    idle(); step();
    put(1'b1, 2, 0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; check("raw_d2", int'(fwd[1:0]), 2); step();
    drain();
    put(1'b1, 0, 0, 0, 2, 1'b1, 1'b0, 1'b0, 1'b0); step();
    idle(); step(); step();
    put(1'b1, 2, 0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; check("raw_d3", int'(fwd[1:0]), int'(WB_CODE)); step();
    drain();

    // Load-use: one stall, then MEM forward.
    put(1'b1, 0, 0, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0); step();
    put(1'b1, 0, 1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; check("lu_stall", int'(stall), 1); check("lu_bubble", int'(bubble), 1); step();
    #1; check("lu_release", int'(stall), 0); check("lu_fwd", int'(fwd[3:2]), 2); step();
    drain();

    // Branch flush kills EX, MEM still reaches WB.
    put(1'b1, 0, 0, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0); step();
    put(1'b1, 0, 0, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0); step();
    put(1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1; check("br_flush", int'(flush), 1); step();
    put(1'b1, 3, 1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; check("br_killed", int'(fwd[1:0]), 0); check("br_wb", int'(fwd[3:2]), int'(WB_CODE)); step();
    drain();

    // mem_wait over a pending load-use with branch.
    put(1'b1, 0, 0, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0); step();
    put(1'b1, 0, 1, 2, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) begin
      #1; check("mw_freeze", int'(freeze), 1); check("mw_stall", int'(stall), 1);
      check("mw_flush", int'(flush), 0);
      step();
    end
    mem_wait = 1'b0;
    #1; check("mw_then_flush", int'(flush), 1); check("mw_then_stall", int'(stall), 0); step();
    drain();

    // Randomized traffic; small register space keeps dependencies frequent.
    repeat (400) begin
      reset_n = ($urandom_range(0, 39) != 0);
      put(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
